instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8: program-counter and memory-address width.
REQ-002 SHALL have parameter INSTR_W, default 16: instruction width; opcode = instr[INSTR_W-1:INSTR_W-3].
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port run  input  1  level; 1 = fetch/execute continuously.
REQ-007 SHALL have port mem_addr  output  PC_W  instruction fetch address.
REQ-008 SHALL have port mem_rd  output  1  fetch request.
REQ-009 SHALL have port mem_rdata  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port mem_valid  input  1  mem_rdata valid this cycle.
REQ-011 SHALL have port instr  output  INSTR_W  instruction register, feeds the datapath controller decode fields.
REQ-012 SHALL have port start  output  1  start request to the datapath controller.
REQ-013 SHALL have port waiting  input  1  datapath controller idle, ready for start.
REQ-014 SHALL have port pc  output  PC_W  current program counter.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE and HALT.
REQ-016 SHALL have port halted  output  1  high in HALT.
REQ-017 SHALL have port instr_count  output  16  retired-instruction count.

Function
REQ-018 SHALL implement the Moore FSM IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, HALT; all outputs are registers or decodes of the state only.
REQ-019 IDLE: when run=1 and waiting=1, go to FETCH on the next edge; otherwise stay.
REQ-020 FETCH: mem_rd=1, mem_addr=pc; on an edge with mem_valid=1, load instr<=mem_rdata and go to DECODE; hold mem_rd indefinitely until then.
REQ-021 mem_valid SHALL be ignored outside FETCH.
REQ-022 DECODE: opcode 3'b111 -> HALT; any other opcode -> ISSUE.
REQ-023 ISSUE: start=1; stay until an edge with waiting=0, then go to WAIT_DONE; start is 0 in all other states.
REQ-024 WAIT_DONE: on an edge with waiting=1, pc<=pc+1 (mod 2^PC_W, so 255 wraps to 0), retire the instruction, and go to FETCH if run=1, else IDLE.
REQ-025 Deasserting run SHALL NOT abort an in-flight instruction; it takes effect only at the WAIT_DONE exit or in IDLE.
REQ-026 HALT SHALL be absorbing until reset; pc is not incremented, and the halt instruction is not retired.
REQ-027 Minimum latency, from IDLE leaving to the next FETCH, SHALL be 5 edges when mem_valid and waiting respond in one cycle.
REQ-028 instr SHALL change only on the FETCH capture edge.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, pc=0, instr=0, instr_count=0, mem_rd=0, start=0, busy=0, halted=0, and mem_addr=0.
REQ-030 Reset asserted mid-operation, including in ISSUE or HALT, SHALL abandon the instruction with no retire; deassertion is synchronised to the next clk edge.

Configuration
REQ-031 Macro INSTR_SEQUENCER_PERF_CNT_EN: when defined, instr_count SHALL increment by 1 at each retire (REQ-024), saturating at 16'hFFFF.
REQ-032 When INSTR_SEQUENCER_PERF_CNT_EN is undefined, instr_count SHALL be constant 0 and no counter flops are synthesised; all other behaviour is identical.

Verification
REQ-033 Reset, run=1, mem returns 16'hA000 after 1 cycle, waiting drops 1 cycle after start and returns 3 cycles later -> exactly one start pulse episode, pc 0->1, instr=16'hA000, instr_count=1 (macro on).
REQ-034 mem_valid delayed 4 cycles in FETCH -> mem_rd held high 5 cycles, mem_addr stable, no start until capture.
REQ-035 Fetch 16'hE000 (opcode 111) at pc=3 -> HALT, halted=1, pc stays 3, start never asserted, run toggling has no effect until rst_n low.
REQ-036 Preload pc=255 via 255 retires -> next retire gives pc=0 and fetch at mem_addr=0.
REQ-037 Drop run during WAIT_DONE -> instruction completes, pc increments, FSM enters IDLE with busy=0, mem_rd=0.
REQ-038 Assert rst_n=0 in ISSUE -> start drops with no clock edge, pc=0, instr_count=0; with macro off, instr_count reads 0 throughout REQ-033.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches, decodes and issues instructions to a datapath controller.
// Optional retired-instruction counter enabled by defining INSTR_SEQUENCER_PERF_CNT_EN.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               start,
  input  logic               waiting,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic               mem_rd_r, start_r, busy_r, halted_r;
  logic               capture_s, retire_s;

  // Next-state decode; capture and retire strobes mark the two data-update edges.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    retire_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run && waiting) state_s = S_FETCH;
        else                state_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem_valid) begin
          capture_s = 1'b1;
          state_s   = S_DECODE;
        end else begin
          state_s   = S_FETCH;
        end
      end
      S_DECODE: begin
        if (instr_r[INSTR_W-1 -: 3] == 3'b111) state_s = S_HALT;
        else                                   state_s = S_ISSUE;
      end
      S_ISSUE: begin
        if (!waiting) state_s = S_WAIT_DONE;
        else          state_s = S_ISSUE;
      end
      S_WAIT_DONE: begin
        if (waiting) begin
          retire_s = 1'b1;
          state_s  = run ? S_FETCH : S_IDLE;
        end else begin
          state_s  = S_WAIT_DONE;
        end
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // State, datapath registers and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      pc_r     <= {PC_W{1'b0}};
      instr_r  <= {INSTR_W{1'b0}};
      mem_rd_r <= 1'b0;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      mem_rd_r <= (state_s == S_FETCH);
      start_r  <= (state_s == S_ISSUE);
      busy_r   <= (state_s != S_IDLE) && (state_s != S_HALT);
      halted_r <= (state_s == S_HALT);
      if (capture_s) instr_r <= mem_rdata;
      if (retire_s)  pc_r    <= pc_r + PC_ONE;
    end
  end

`ifdef INSTR_SEQUENCER_PERF_CNT_EN
  logic [15:0] instr_count_r;

  // Saturating count of retired instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_r <= 16'h0000;
    end else if (retire_s && (instr_count_r != 16'hFFFF)) begin
      instr_count_r <= instr_count_r + 16'h0001;
    end
  end

  assign instr_count = instr_count_r;
`else
  assign instr_count = 16'h0000;
`endif

  assign mem_addr = pc_r;
  assign pc       = pc_r;
  assign instr    = instr_r;
  assign mem_rd   = mem_rd_r;
  assign start    = start_r;
  assign busy     = busy_r;
  assign halted   = halted_r;

endmodule
